// File: rtl/mem_sp_ctrl.sv
// mem_sp_ctrl: parametrised single-port synchronous RAM controller.
// It has a valid/ready request port, per-byte write enables, read data
// registered with one cycle of latency, and a hardware zeroing sweep that
// runs after reset and on a 'clear' pulse.
// Ports:
//   clock, reset   - single clock, asynchronous active-high reset
//   clear          - pulse, restarts the zeroing sweep (honoured in IDLE only)
//   req_valid/req_ready, req_write, req_addr, req_wdata, req_be - request port
//   rsp_valid, rsp_rdata - read response (pulse / held data)
//   init_done      - high once the sweep has completed
module mem_sp_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [BE_WIDTH-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  init_done_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic [BE_WIDTH-1:0]   mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Ready drops combinationally with clear so the clear cycle never accepts
  assign req_ready = (state_q == ST_IDLE) && !clear;
  assign accept    = req_valid && req_ready;

  // Array write port: the sweep owns the port while in CLEAR
  always_comb begin
    mem_we    = '0;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    if (state_q == ST_CLEAR) begin
      mem_we    = '1;
      mem_addr  = cnt_q;
      mem_wdata = '0;
    end else if (accept && req_write) begin
      mem_we = req_be;
    end
  end

  // Storage: contents survive reset, only the sweep zeroes them
  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(BE_WIDTH); i++) begin
      if (mem_we[i]) begin
        mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Control FSM with registered response and status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (state_q == ST_CLEAR) begin
        cnt_q <= cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == '1) begin
          state_q     <= ST_IDLE;
          init_done_q <= 1'b1;
        end
      end else begin
        if (clear) begin
          state_q     <= ST_CLEAR;
          cnt_q       <= '0;
          init_done_q <= 1'b0;
        end else if (accept && !req_write) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= mem[req_addr];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_mem_sp_ctrl.sv
// Directed bench for mem_sp_ctrl: a small instance (ADDR_WIDTH=4) covers
// sweep length, mid-sweep clear and reset behaviour; a default-geometry
// instance covers data traffic, byte enables, read-after-write and clear.
module tb_mem_sp_ctrl;

  logic        clk = 1'b0;
  logic        rst_s, rst_b;
  logic        clr_s, clr_b;
  logic        req_valid, req_write;
  logic [11:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;

  logic        s_ready, s_rvalid, s_done;
  logic [15:0] s_rdata;
  logic        b_ready, b_rvalid, b_done;
  logic [15:0] b_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_sp_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) u_small (
    .clock(clk), .reset(rst_s), .clear(clr_s),
    .req_valid(req_valid), .req_ready(s_ready), .req_write(req_write),
    .req_addr(req_addr[3:0]), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(s_rvalid), .rsp_rdata(s_rdata), .init_done(s_done)
  );

  mem_sp_ctrl u_big (
    .clock(clk), .reset(rst_b), .clear(clr_b),
    .req_valid(req_valid), .req_ready(b_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(b_rvalid), .rsp_rdata(b_rdata), .init_done(b_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [15:0] d, input logic [1:0] be);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  // Issue a read; after the accept edge check response valid and data
  task automatic rd(input string tag, input bit big, input logic [11:0] a, input logic [15:0] exp);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_vld"}, big ? 32'(b_rvalid) : 32'(s_rvalid), 32'd1);
    check({tag, "_dat"}, big ? 32'(b_rdata) : 32'(s_rdata), 32'(exp));
  endtask

  // Count rising edges until init_done, starting from the current point
  task automatic wait_sweep(input string tag, input bit big, input int start, input int exp);
    int n = start;
    while (!(big ? b_done : s_done) && n < 6000) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    int n;
    rst_s = 1'b1; rst_b = 1'b1; clr_s = 1'b0; clr_b = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    #3;
    check("rst_s_ready", 32'(s_ready),  32'd0);
    check("rst_s_rvld",  32'(s_rvalid), 32'd0);
    check("rst_s_rdata", 32'(s_rdata),  32'd0);
    check("rst_s_done",  32'(s_done),   32'd0);
    check("rst_b_ready", 32'(b_ready),  32'd0);
    check("rst_b_done",  32'(b_done),   32'd0);

    // Small instance: sweep length and zeroed contents
    @(negedge clk); rst_s = 1'b0;
    wait_sweep("s_sweep", 1'b0, 0, 16);
    check("s_ready_idle", 32'(s_ready), 32'd1);
    for (int i = 0; i < 16; i++) rd($sformatf("s_zero%0d", i), 1'b0, 12'(i), 16'h0000);
    @(posedge clk); #1;
    check("s_rvld_drop", 32'(s_rvalid), 32'd0);

    wr(12'h00F, 16'h5A5A, 2'b11);
    rd("s_wr_f", 1'b0, 12'h00F, 16'h5A5A);

    // Clear in IDLE, second clear mid-sweep must not extend it
    @(negedge clk); clr_s = 1'b1;
    #1 check("s_clr_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1; clr_s = 1'b0;
    check("s_clr_done", 32'(s_done), 32'd0);
    n = 0;
    repeat (5) begin @(posedge clk); #1; n++; end
    @(negedge clk); clr_s = 1'b1;
    @(posedge clk); #1; n++; clr_s = 1'b0;
    check("s_mid_done", 32'(s_done), 32'd0);
    wait_sweep("s_clr_sweep", 1'b0, n, 16);
    rd("s_clr_f", 1'b0, 12'h00F, 16'h0000);

    // Reset during a read response cycle
    wr(12'h003, 16'h7777, 2'b11);
    rd("s_pre_rst", 1'b0, 12'h003, 16'h7777);
    #1 rst_s = 1'b1;
    #1;
    check("s_rst_rvld",  32'(s_rvalid), 32'd0);
    check("s_rst_rdata", 32'(s_rdata),  32'd0);
    check("s_rst_done",  32'(s_done),   32'd0);
    check("s_rst_ready", 32'(s_ready),  32'd0);
    @(negedge clk); rst_s = 1'b0;
    wait_sweep("s_rst_sweep", 1'b0, 0, 16);

    // Reset during the sweep
    @(negedge clk); rst_s = 1'b1;
    @(negedge clk); rst_s = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_s = 1'b1;
    #1 check("s_rst_mid_done", 32'(s_done), 32'd0);
    @(negedge clk); rst_s = 1'b0;
    wait_sweep("s_rst_mid_sweep", 1'b0, 0, 16);

    // Default geometry instance
    @(negedge clk); rst_b = 1'b0;
    wait_sweep("b_sweep", 1'b1, 0, 4096);
    wr(12'h1A1, 16'd81, 2'b11);
    check("b_wr_norsp", 32'(b_rvalid), 32'd0);
    wr(12'h123, 16'd43, 2'b11);
    rd("b_b2b_a", 1'b1, 12'h1A1, 16'd81);
    rd("b_b2b_b", 1'b1, 12'h123, 16'd43);
    @(posedge clk); #1;
    check("b_rvld_drop", 32'(b_rvalid), 32'd0);
    check("b_rdata_hold", 32'(b_rdata), 32'd43);

    wr(12'h1A1, 16'hABCD, 2'b11);
    wr(12'h1A1, 16'h1234, 2'b01);
    rd("b_be01", 1'b1, 12'h1A1, 16'hAB34);
    wr(12'h1A1, 16'hFFFF, 2'b00);
    rd("b_be00", 1'b1, 12'h1A1, 16'hAB34);
    wr(12'h1A1, 16'hEE00, 2'b10);
    rd("b_be10", 1'b1, 12'h1A1, 16'hEE34);

    wr(12'h123, 16'd74, 2'b11);
    rd("b_raw", 1'b1, 12'h123, 16'd74);

    // Clear with a concurrent read request: the read is not accepted
    @(negedge clk);
    clr_b = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h1A1;
    #1 check("b_clr_ready", 32'(b_ready), 32'd0);
    @(posedge clk); #1;
    clr_b = 1'b0; req_valid = 1'b0;
    check("b_clr_norsp", 32'(b_rvalid), 32'd0);
    check("b_clr_done",  32'(b_done),   32'd0);
    wait_sweep("b_clr_sweep", 1'b1, 0, 4096);
    rd("b_clr_1a1", 1'b1, 12'h1A1, 16'h0000);
    rd("b_clr_123", 1'b1, 12'h123, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_sp_ctrl.md
# mem_sp_ctrl

Parametrised single-port synchronous RAM with a valid/ready request port, per-byte write enables, registered read data and a hardware clear sweep. It is the successor to the team's fixed 4K x 16 memory: it keeps the same default geometry, replaces the bidirectional data bus with separate write and read buses, and adds a one-cycle-latency read response. Sits between a master (CPU or DMA sequencer) and storage; the master must wait for `init_done` before issuing traffic.

## Interface
- `DATA_WIDTH`, 16, word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 12, address width; depth = 2**ADDR_WIDTH words.
- `BE_WIDTH`, DATA_WIDTH/8, derived; number of byte lanes (not overridden).
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clear`  in  1  single-cycle pulse that re-runs the zeroing sweep; honoured only in IDLE.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `req_be`  in  BE_WIDTH  byte enables; bit i covers `wdata[8i+7:8i]`.
- `rsp_valid`  out  1  one-cycle pulse carrying read data.
- `rsp_rdata`  out  DATA_WIDTH  read data; holds its last value between pulses.
- `init_done`  out  1  high once the clear sweep has completed.

## Operation
- States: CLEAR and IDLE. `reset` forces CLEAR with the sweep counter at 0.
- CLEAR: each cycle writes 0 to `mem[counter]` and increments the counter.
  - When the counter equals 2**ADDR_WIDTH-1, that final write is done and the next state is IDLE.
  - `req_ready`=0 and `init_done`=0 throughout CLEAR.
- IDLE: `req_ready`=1, `init_done`=1. A request is accepted when `req_valid && req_ready` at a rising edge.
- Write accept: for every i with `req_be[i]`=1, byte lane i of `mem[req_addr]` takes `req_wdata` lane i; other lanes keep their contents.
  - A write with `req_be`=0 changes nothing.
  - A write produces no response.
- Read accept: `rsp_rdata` takes `mem[req_addr]` and `rsp_valid` goes to 1 at the same edge. `rsp_valid` returns to 0 at the next edge unless another read is accepted there.
- Back-to-back reads are accepted every cycle; `rsp_valid` stays high for each one.
- `clear` sampled high in IDLE: that cycle's request is not accepted (`req_ready` is already low combinationally when `clear`=1), and the block moves to CLEAR with the counter at 0.
- `clear` in CLEAR is ignored; the sweep is not restarted.
- Memory contents are not affected by `reset` itself, only by the sweep that follows it.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `init_done`=0, state CLEAR, counter 0.
- Sweep length: 2**ADDR_WIDTH cycles. `init_done` and `req_ready` rise at the edge that completes the last clear write (4096 cycles after reset release at the default geometry).
- Read latency: 1 cycle, accept edge to `rsp_valid`. Data is the array content before any write at that same edge; there is no simultaneous write, since the port is single-port.
- Read-after-write: a write accepted at edge N followed by a read of the same address accepted at edge N+1 returns the new data.
- `reset` asserted mid-sweep or mid-traffic: outputs take reset values immediately (asynchronously). A pending `rsp_valid` is dropped, and the sweep restarts at address 0 after release.
- `req_ready` = (state==IDLE) && !`clear`; it is the only combinational output.

## Test plan
- Reset release with ADDR_WIDTH=4 → `init_done`=0 for exactly 16 cycles, then 1. Reads of 0x0..0xF return 0.
- Write 0x1A1 ← 81 and 0x123 ← 43 with `req_be`=2'b11; read 0x1A1 then 0x123 back-to-back → `rsp_valid` high for 2 consecutive cycles with 81 then 43.
- Byte enables: write 0x1A1 ← 0xABCD with be=11, then 0x1A1 ← 0x1234 with be=01 → read returns 0xAB34. A further write with be=00 leaves it at 0xAB34.
- Read-after-write: write 0x123 ← 74 at edge N, read 0x123 at edge N+1 → `rsp_rdata`=74 after edge N+1.
- Pulse `clear` in IDLE after writes → `req_ready` drops that cycle and `init_done` is low for the sweep. Afterwards 0x1A1 and 0x123 read 0. A second `clear` mid-sweep does not extend the sweep.
- Assert `reset` during a read-response cycle and during the sweep → `rsp_valid`/`init_done` drop immediately, and a full-length sweep follows release.
